// File: rtl/alu_pkg.sv
// Shared types for the datapath ALU: operation select encoding.
package alu_pkg;

  // Codes 6 and 7 are reserved and produce a zero result.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_INV = 3'd5
  } alu_func_e;

endpackage

// File: rtl/alu.sv
// Integer ALU: combinational result onto a tri-state bus, plus a flag register
// (zero, positive, carry/borrow, signed overflow) captured when enabled.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  alu_func_e         alu_func,
  input  logic              output_enable,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero_flag,
  output logic              positive_flag,
  output logic              carry_flag,
  output logic              signed_overflow
);

  localparam int unsigned MSB = DATA_W - 1;

  logic [DATA_W:0]   sum_c;
  logic [DATA_W:0]   diff_c;
  logic [DATA_W-1:0] result_c;
  logic              carry_c;
  logic              ovf_c;
  logic              zero_c;
  logic              pos_c;

  // Extended add/subtract: the top bit is carry-out for ADD and borrow for SUB.
  assign sum_c  = {1'b0, operand_a} + {1'b0, operand_b};
  assign diff_c = {1'b0, operand_a} - {1'b0, operand_b};

  always_comb begin
    result_c = '0;
    carry_c  = 1'b0;
    ovf_c    = 1'b0;
    case (alu_func)
      ALU_ADD: begin
        result_c = sum_c[DATA_W-1:0];
        carry_c  = sum_c[DATA_W];
        ovf_c    = (operand_a[MSB] == operand_b[MSB]) && (result_c[MSB] != operand_a[MSB]);
      end
      ALU_SUB: begin
        result_c = diff_c[DATA_W-1:0];
        carry_c  = diff_c[DATA_W];
        ovf_c    = (operand_a[MSB] != operand_b[MSB]) && (result_c[MSB] != operand_a[MSB]);
      end
      ALU_AND: result_c = operand_a & operand_b;
      ALU_OR:  result_c = operand_a | operand_b;
      ALU_XOR: result_c = operand_a ^ operand_b;
      ALU_INV: result_c = ~operand_a;
      default: result_c = '0;
    endcase
  end

  assign zero_c = (result_c == '0);
  assign pos_c  = ~result_c[MSB] & ~zero_c;

  // Bus is released whenever the ALU is not enabled, independent of the clock.
  assign alu_result = output_enable ? result_c : {DATA_W{1'bz}};

  // Flags capture only on enabled cycles so later compare/branch logic sees the last real op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_flag       <= 1'b0;
      positive_flag   <= 1'b0;
      carry_flag      <= 1'b0;
      signed_overflow <= 1'b0;
    end else if (output_enable) begin
      zero_flag       <= zero_c;
      positive_flag   <= pos_c;
      carry_flag      <= carry_c;
      signed_overflow <= ovf_c;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, tri-state/hold sequence,
// and random operations against an arithmetic reference model.
module tb_alu;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    alu_func_e  func;
    logic [7:0] res;
    logic       z;
    logic       p;
    logic       c;
    logic       o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  alu_func_e   func;
  logic        oe;
  tri   [W-1:0] bus;
  logic        zf, pf, cf, of;

  int errors = 0;
  int checks = 0;

  vec_t vecs[13];

  // Released bus bits float high so a disabled ALU is observable.
  for (genvar i = 0; i < int'(W); i++) begin : g_pu
    pullup (bus[i]);
  end

  alu #(.DATA_W(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .operand_a      (a),
    .operand_b      (b),
    .alu_func       (func),
    .output_enable  (oe),
    .alu_result     (bus),
    .zero_flag      (zf),
    .positive_flag  (pf),
    .carry_flag     (cf),
    .signed_overflow(of)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic ez, input logic ep,
                           input logic ec, input logic eo);
    chk({name, " flags zpco"}, {28'd0, zf, pf, cf, of}, {28'd0, ez, ep, ec, eo});
  endtask

  // Reference computed from the arithmetic meaning of each operation.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input alu_func_e mf,
                       output logic [7:0] r, output logic z, output logic p,
                       output logic c, output logic o);
    int ua, ub, sa, sb, s, u;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    c = 1'b0;
    o = 1'b0;
    u = 0;
    case (int'(mf))
      0: begin
        u = (ua + ub) % 256;
        c = (ua + ub) > 255;
        s = sa + sb;
        o = (s > 127) || (s < -128);
      end
      1: begin
        u = (ua - ub + 256) % 256;
        c = ua < ub;
        s = sa - sb;
        o = (s > 127) || (s < -128);
      end
      2: u = int'(ma & mb);
      3: u = int'(ma | mb);
      4: u = int'(ma ^ mb);
      5: u = 255 - ua;
      default: u = 0;
    endcase
    r = 8'(u);
    z = (u == 0);
    p = (u != 0) && (u < 128);
  endtask

  task automatic apply(input vec_t v);
    a = v.a;
    b = v.b;
    func = v.func;
    oe = 1'b1;
    #1;
    chk({v.name, " result"}, {24'd0, bus}, {24'd0, v.res});
    @(posedge clk);
    #1;
    chk_flags(v.name, v.z, v.p, v.c, v.o);
  endtask

  initial begin
    logic [7:0] er;
    logic ez, ep, ec, eo;
    vec_t rv;

    vecs[0]  = '{"add_10_20",  8'h10, 8'h20, ALU_ADD, 8'h30, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{"add_ff_01",  8'hFF, 8'h01, ALU_ADD, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{"add_7f_01",  8'h7F, 8'h01, ALU_ADD, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{"sub_30_10",  8'h30, 8'h10, ALU_SUB, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{"sub_10_30",  8'h10, 8'h30, ALU_SUB, 8'hE0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{"sub_00_01",  8'h00, 8'h01, ALU_SUB, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{"sub_80_01",  8'h80, 8'h01, ALU_SUB, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{"and_aa_55",  8'hAA, 8'h55, ALU_AND, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{"or_aa_55",   8'hAA, 8'h55, ALU_OR,  8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{"xor_ff_ff",  8'hFF, 8'hFF, ALU_XOR, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{"inv_aa",     8'hAA, 8'h33, ALU_INV, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{"inv_ff",     8'hFF, 8'h12, ALU_INV, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{"reserved6",  8'h12, 8'h34, alu_func_e'(3'd6), 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset wins over an enabled ADD of zeros.
    rst_n = 1'b0;
    oe    = 1'b1;
    a     = 8'h00;
    b     = 8'h00;
    func  = ALU_ADD;
    @(posedge clk);
    #1;
    chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_flags("post_reset", 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 13; i++) apply(vecs[i]);

    // Disabled: bus released, flags from the reserved op (Z=1) held across edges.
    oe   = 1'b0;
    a    = 8'h55;
    b    = 8'h55;
    func = ALU_ADD;
    #1;
    chk("hold bus released", {24'd0, bus}, 32'h0000_00FF);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_flags("hold", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    oe = 1'b1;
    #1;
    chk("enable bus", {24'd0, bus}, 32'h0000_00AA);
    @(posedge clk);
    #1;
    chk_flags("enable", 1'b0, 1'b0, 1'b0, 1'b1);

    // Random valid operations against the reference model.
    for (int i = 0; i < 100; i++) begin
      rv.name = "random";
      rv.a    = 8'($urandom);
      rv.b    = 8'($urandom);
      rv.func = alu_func_e'(3'($urandom_range(0, 5)));
      model(rv.a, rv.b, rv.func, er, ez, ep, ec, eo);
      rv.res = er;
      rv.z   = ez;
      rv.p   = ep;
      rv.c   = ec;
      rv.o   = eo;
      apply(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Parameterised integer ALU for the CPU datapath.
- Computes one of six arithmetic/logic functions on two operands and drives the result onto a shared data bus through a tri-state output.
- Condition flags (zero, positive, carry, signed overflow) are captured in a flag register on the clock edge when the ALU is enabled, for use by later branch/compare logic.

Parameters:
- DATA_W, 8, operand/result width in bits (must be >= 2).

Ports:
- clk  input  1  system clock; flags update on rising edge.
- rst_n  input  1  synchronous active-low reset.
- operand_a  input  DATA_W  first operand (A).
- operand_b  input  DATA_W  second operand (B); ignored by INV.
- alu_func  input  alu_func_e (3 bits, from alu_pkg)  operation select.
- output_enable  input  1  1 = drive alu_result and capture flags; 0 = bus released, flags held.
- alu_result  output (tri-state)  DATA_W  operation result, or high-Z when disabled.
- zero_flag  output  1  registered: last captured result == 0.
- positive_flag  output  1  registered: last captured result strictly positive as signed (MSB==0 and result!=0).
- carry_flag  output  1  registered: unsigned carry-out (ADD) / borrow (SUB).
- signed_overflow  output  1  registered: two's-complement overflow (ADD/SUB).

Behaviour:
- alu_func_e encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, INV=5; codes 6 and 7 reserved.
- Combinational result path, zero latency from operands/func to alu_result:
  - ADD: A+B mod 2^DATA_W.
  - SUB: A-B mod 2^DATA_W.
  - AND: A&B.
  - OR: A|B.
  - XOR: A^B.
  - INV: ~A.
  - Reserved codes: result 0.
- Tri-state: alu_result = computed value when output_enable=1, all bits 'z' when 0. Asynchronous with respect to clk.
- Next-flag logic (combinational, from computed result R):
  - Z = (R==0).
  - P = ~R[MSB] & (R!=0).
  - ADD: C = carry-out of the (DATA_W+1)-bit sum; O = (A[MSB]==B[MSB]) & (R[MSB]!=A[MSB]).
  - SUB: C = 1 iff A<B unsigned (borrow); O = (A[MSB]!=B[MSB]) & (R[MSB]!=A[MSB]).
  - AND/OR/XOR/INV/reserved: C=0, O=0.
- Flag register, rising edge of clk:
  - rst_n==0: all four flags <= 0 (reset has priority over output_enable).
  - else if output_enable==1: flags <= next-flag values.
  - else: flags hold.
- Flags therefore lag the result by one cycle: visible the cycle after the enabled operation.
- Reset does not affect alu_result; result depends only on current inputs and output_enable.
- No internal state other than the four flag bits.

Test Plan:
- Reset: rst_n=0 for one edge with output_enable=1, A=00, B=00, ADD -> after edge Z=P=C=O=0; release reset, one more edge -> Z=1, others 0.
- ADD: 10+20 -> alu_result=30, after edge Z0 P1 C0 O0. FF+01 -> 00, Z1 P0 C1 O0. 7F+01 -> 80, Z0 P0 C0 O1.
- SUB: 30-10 -> 20, C0 O0 P1. 10-30 -> E0, C1 O0 P0. 00-01 -> FF, C1. 80-01 -> 7F, C0 O1 P1.
- Logic ops: AA&55 -> 00 Z1; AA|55 -> FF; FF^FF -> 00 Z1; INV of AA -> 55 (B ignored), INV of FF -> 00. Each with C0 O0 after edge.
- Tri-state/hold: A=55, B=55, ADD, output_enable=0 -> alu_result=zz, flags unchanged across several edges. Set output_enable=1 -> alu_result=AA; after edge P0 O1 C0 Z0.
- Random: 100 vectors of random A, B and valid func with output_enable=1 -> alu_result and registered flags match a reference model (next-edge compare).
